// File: rtl/psram_rd_checker.sv
// ---------------------------------------------------------------------------
// psram_rd_checker
//
// Purpose:
//   Read-data checker that sits downstream of psram_controller, beside
//   psram_rw. It snoops the command bus psram_rw drives. For every read burst
//   it predicts the address-seeded pattern (addr_in[15:0] + beat index) and
//   compares it against psram_rd_data on each psram_rd_valid beat. It reports
//   pass/fail, error counts, sticky error types and the first failing beat.
//
// Parameters:
//   BIT_MODE  16 = compare the full 16-bit word, 8 = compare [7:0] only
//   WRAP_LEN  beat count at which the expected index wraps when wrap_in=1
//   TIMEOUT   max sys_clk cycles from exe/beat to the next beat or done
//
// Ports:
//   sys_clk         in   system clock, rising edge
//   sys_rst         in   asynchronous active-low reset
//   psram_exe       in   command strobe (1-cycle pulse)
//   rw_ctrl         in   1 = read, 0 = write (sampled with psram_exe)
//   wrap_in         in   wrapped-burst flag (sampled with psram_exe)
//   addr_in  [31:0] in   burst start address (sampled with psram_exe)
//   burst_len[11:0] in   burst length in beats, 0 means 4096
//   psram_rd_valid  in   read beat valid
//   psram_rd_data   in   read beat data
//   psram_done      in   end-of-transaction pulse
//   chk_clr         in   synchronous clear of statistics and sticky flags
//   chk_busy        out  a read burst is being checked
//   chk_pass        out  >=1 burst completed and no error since clear
//   chk_fail        out  any error recorded since clear
//   err_cnt  [15:0] out  data-mismatch beats, saturating
//   burst_cnt[15:0] out  read bursts completed, wraps
//   first_err_addr  out  address of the first mismatching beat
//   first_err_data  out  data of the first mismatching beat
//   err_type [3:0]  out  sticky {timeout, protocol, underrun, overrun}
//   dbg_state       out  FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: there is no backpressure. A beat is transferred on every cycle
// psram_rd_valid is high; psram_exe and psram_done are single-cycle strobes
// that take effect on the edge where they are sampled high.
// ---------------------------------------------------------------------------
module psram_rd_checker #(
    parameter int BIT_MODE = 16,
    parameter int WRAP_LEN = 32,
    parameter int TIMEOUT  = 4096
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        psram_exe,
    input  logic        rw_ctrl,
    input  logic        wrap_in,
    input  logic [31:0] addr_in,
    input  logic [11:0] burst_len,
    input  logic        psram_rd_valid,
    input  logic [15:0] psram_rd_data,
    input  logic        psram_done,
    input  logic        chk_clr,
    output logic        chk_busy,
    output logic        chk_pass,
    output logic        chk_fail,
    output logic [15:0] err_cnt,
    output logic [15:0] burst_cnt,
    output logic [31:0] first_err_addr,
    output logic [15:0] first_err_data,
    output logic [3:0]  err_type,
    output logic        dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int          TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [12:0] WRAP_LAST  = 13'(WRAP_LEN - 1);
    localparam logic [15:0] CMP_MASK   = (BIT_MODE == 8) ? 16'h00FF : 16'hFFFF;

    // Burst context
    state_t        state_q;
    logic [31:0]   addr_q;
    logic [12:0]   len_q;     // 1..4096
    logic          wrap_q;
    logic [12:0]   beat_q;    // beats accepted for comparison
    logic [12:0]   idx_q;     // expected-pattern index (wraps when wrap_q)
    logic [TW-1:0] timer_q;

    // One-cycle compare result stage
    logic          pend_err_q;
    logic [31:0]   pend_addr_q;
    logic [15:0]   pend_data_q;

    // Statistics
    logic [15:0]   err_cnt_q,        err_cnt_d;
    logic [15:0]   burst_cnt_q,      burst_cnt_d;
    logic [31:0]   first_err_addr_q, first_err_addr_d;
    logic [15:0]   first_err_data_q, first_err_data_d;
    logic [3:0]    err_type_q,       err_type_d;

    // Per-cycle events
    logic          in_run;
    logic          beat_rx;
    logic          beat_cmp;
    logic          ev_overrun;
    logic          ev_underrun;
    logic          ev_proto;
    logic          ev_timeout;
    logic          ev_done;
    logic [12:0]   beats_total;
    logic [15:0]   exp_word;
    logic          mismatch;

    always_comb begin
        in_run      = (state_q == S_RUN);
        beat_rx     = in_run & psram_rd_valid;
        beat_cmp    = beat_rx & (beat_q < len_q);
        ev_overrun  = beat_rx & (beat_q >= len_q);
        // Same-cycle beat counts toward the length check at done.
        beats_total = beat_q + {12'd0, beat_cmp};
        ev_done     = in_run & psram_done;
        ev_underrun = ev_done & (beats_total < len_q);
        ev_proto    = (in_run & psram_exe) | (~in_run & psram_rd_valid);
        ev_timeout  = in_run & ~psram_rd_valid & ~psram_done & (timer_q == TIMER_LAST);
        exp_word    = addr_q[15:0] + idx_q[12:0];
        mismatch    = (((psram_rd_data ^ exp_word) & CMP_MASK) != 16'd0);
    end

    // Burst-tracking FSM
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            len_q   <= 13'd0;
            wrap_q  <= 1'b0;
            beat_q  <= 13'd0;
            idx_q   <= 13'd0;
            timer_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (psram_exe && rw_ctrl) begin
                        state_q <= S_RUN;
                        addr_q  <= addr_in;
                        len_q   <= (burst_len == 12'd0) ? 13'd4096 : {1'b0, burst_len};
                        wrap_q  <= wrap_in;
                        beat_q  <= 13'd0;
                        idx_q   <= 13'd0;
                        timer_q <= '0;
                    end
                end
                S_RUN: begin
                    if (psram_rd_valid) begin
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                    if (beat_cmp) begin
                        beat_q <= beat_q + 13'd1;
                        if (wrap_q && (idx_q == WRAP_LAST)) begin
                            idx_q <= 13'd0;
                        end else begin
                            idx_q <= idx_q + 13'd1;
                        end
                    end
                    if (psram_done || ev_timeout) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Compare result is registered; statistics consume it a cycle later.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pend_err_q  <= 1'b0;
            pend_addr_q <= 32'd0;
            pend_data_q <= 16'd0;
        end else begin
            pend_err_q  <= beat_cmp & mismatch;
            pend_addr_q <= addr_q + {19'd0, idx_q};
            pend_data_q <= psram_rd_data;
        end
    end

    always_comb begin
        err_cnt_d        = err_cnt_q;
        burst_cnt_d      = burst_cnt_q;
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        err_type_d       = err_type_q;
        if (chk_clr) begin
            // Clear wins over any update arriving in the same cycle.
            err_cnt_d        = 16'd0;
            burst_cnt_d      = 16'd0;
            first_err_addr_d = 32'd0;
            first_err_data_d = 16'd0;
            err_type_d       = 4'd0;
        end else begin
            if (pend_err_q) begin
                if (err_cnt_q == 16'd0) begin
                    first_err_addr_d = pend_addr_q;
                    first_err_data_d = pend_data_q;
                end
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end
            err_type_d = err_type_q | {ev_timeout, ev_proto, ev_underrun, ev_overrun};
            if (ev_done) begin
                burst_cnt_d = burst_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            err_cnt_q        <= 16'd0;
            burst_cnt_q      <= 16'd0;
            first_err_addr_q <= 32'd0;
            first_err_data_q <= 16'd0;
            err_type_q       <= 4'd0;
        end else begin
            err_cnt_q        <= err_cnt_d;
            burst_cnt_q      <= burst_cnt_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
            err_type_q       <= err_type_d;
        end
    end

    assign chk_busy       = (state_q == S_RUN);
    assign chk_fail       = (|err_type_q) | (err_cnt_q != 16'd0);
    assign chk_pass       = (burst_cnt_q != 16'd0) & ~chk_fail;
    assign err_cnt        = err_cnt_q;
    assign burst_cnt      = burst_cnt_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;
    assign err_type       = err_type_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_psram_rd_checker.sv
module tb_psram_rd_checker;

    localparam int TIMEOUT = 4096;

    logic        sys_clk;
    logic        sys_rst;
    logic        psram_exe;
    logic        rw_ctrl;
    logic        wrap_in;
    logic [31:0] addr_in;
    logic [11:0] burst_len;
    logic        psram_rd_valid;
    logic [15:0] psram_rd_data;
    logic        psram_done;
    logic        chk_clr;
    logic        chk_busy;
    logic        chk_pass;
    logic        chk_fail;
    logic [15:0] err_cnt;
    logic [15:0] burst_cnt;
    logic [31:0] first_err_addr;
    logic [15:0] first_err_data;
    logic [3:0]  err_type;
    logic        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // {busy, pass, fail, err_type, err_cnt, burst_cnt}
    logic [38:0] stat;
    logic [38:0] exp_stat;
    assign stat = {chk_busy, chk_pass, chk_fail, err_type, err_cnt, burst_cnt};

    psram_rd_checker #(
        .BIT_MODE(16),
        .WRAP_LEN(32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .psram_exe     (psram_exe),
        .rw_ctrl       (rw_ctrl),
        .wrap_in       (wrap_in),
        .addr_in       (addr_in),
        .burst_len     (burst_len),
        .psram_rd_valid(psram_rd_valid),
        .psram_rd_data (psram_rd_data),
        .psram_done    (psram_done),
        .chk_clr       (chk_clr),
        .chk_busy      (chk_busy),
        .chk_pass      (chk_pass),
        .chk_fail      (chk_fail),
        .err_cnt       (err_cnt),
        .burst_cnt     (burst_cnt),
        .first_err_addr(first_err_addr),
        .first_err_data(first_err_data),
        .err_type      (err_type),
        .dbg_state     (dbg_state)
    );

    // Clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Driver tasks: inputs change 1ns after the rising edge, outputs are read there too
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_exe(input logic rw, input logic wr, input logic [31:0] a, input logic [11:0] l);
        psram_exe = 1'b1; rw_ctrl = rw; wrap_in = wr; addr_in = a; burst_len = l;
        tick();
        psram_exe = 1'b0; rw_ctrl = 1'b0; wrap_in = 1'b0;
    endtask

    task automatic do_beat(input logic [15:0] d, input logic dn);
        psram_rd_valid = 1'b1; psram_rd_data = d; psram_done = dn;
        tick();
        psram_rd_valid = 1'b0; psram_done = 1'b0;
    endtask

    task automatic do_done();
        psram_done = 1'b1;
        tick();
        psram_done = 1'b0;
    endtask

    task automatic do_clr();
        chk_clr = 1'b1;
        tick();
        chk_clr = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        sys_rst = 1'b0;
        psram_exe = 0; rw_ctrl = 0; wrap_in = 0; addr_in = 0; burst_len = 0;
        psram_rd_valid = 0; psram_rd_data = 0; psram_done = 0; chk_clr = 0;
        tick(); tick();
        exp_stat = '0;
        n_checks++;
        if (stat !== exp_stat) begin
            n_fail++; $display("FAIL reset_status got %h exp %h", stat, exp_stat);
        end
        n_checks++;
        if ({first_err_addr, first_err_data} !== 48'd0) begin
            n_fail++; $display("FAIL reset_first_err got %h exp 0", {first_err_addr, first_err_data});
        end
        sys_rst = 1'b1;
        tick();
    endtask

    task automatic test_clean_burst();
        do_exe(1'b1, 1'b0, 32'h0000_0100, 12'd8);
        n_checks++;
        if (chk_busy !== 1'b1) begin
            n_fail++; $display("FAIL clean_busy got %b exp 1", chk_busy);
        end
        for (int i = 0; i < 8; i++) do_beat(16'h0100 + 16'(i), 1'b0);
        do_done();
        tick();
        exp_stat = {1'b0, 1'b1, 1'b0, 4'h0, 16'd0, 16'd1};
        n_checks++;
        if (stat !== exp_stat) begin
            n_fail++; $display("FAIL clean_status got %h exp %h", stat, exp_stat);
        end
        // 16-bit modulo on the seed: 0xFFFE, 0xFFFF, 0x0000, 0x0001
        do_exe(1'b1, 1'b0, 32'h0001_FFFE, 12'd4);
        for (int i = 0; i < 4; i++) do_beat(16'hFFFE + 16'(i), 1'b0);
        do_done();
        tick();
        exp_stat = {1'b0, 1'b1, 1'b0, 4'h0, 16'd0, 16'd2};
        n_checks++;
        if (stat !== exp_stat) begin
            n_fail++; $display("FAIL modulo_status got %h exp %h", stat, exp_stat);
        end
    endtask

    task automatic test_data_error();
        do_clr();
        do_exe(1'b1, 1'b0, 32'h0000_0100, 12'd8);
        for (int i = 0; i < 3; i++) do_beat(16'h0100 + 16'(i), 1'b0);
        do_beat(16'hDEAD, 1'b0);
        n_checks++;
        if (err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL err_latency got %h exp 0", err_cnt);
        end
        do_beat(16'h0104, 1'b0);
        n_checks++;
        if (err_cnt !== 16'd1) begin
            n_fail++; $display("FAIL err_next_cycle got %h exp 1", err_cnt);
        end
        // Second mismatch must not overwrite first_err_*
        do_beat(16'hBEEF, 1'b0);
        for (int i = 6; i < 8; i++) do_beat(16'h0100 + 16'(i), 1'b0);
        do_done();
        tick();
        exp_stat = {1'b0, 1'b0, 1'b1, 4'h0, 16'd2, 16'd1};
        n_checks++;
        if (stat !== exp_stat) begin
            n_fail++; $display("FAIL err_status got %h exp %h", stat, exp_stat);
        end
        n_checks++;
        if (first_err_addr !== 32'h0000_0103) begin
            n_fail++; $display("FAIL first_err_addr got %h exp 00000103", first_err_addr);
        end
        n_checks++;
        if (first_err_data !== 16'hDEAD) begin
            n_fail++; $display("FAIL first_err_data got %h exp dead", first_err_data);
        end
    endtask

    task automatic test_wrap();
        do_clr();
        do_exe(1'b1, 1'b1, 32'h0000_0000, 12'd40);
        for (int i = 0; i < 40; i++) do_beat(16'(i % 32), 1'b0);
        do_done();
        tick();
        exp_stat = {1'b0, 1'b1, 1'b0, 4'h0, 16'd0, 16'd1};
        n_checks++;
        if (stat !== exp_stat) begin
            n_fail++; $display("FAIL wrap_status got %h exp %h", stat, exp_stat);
        end
    endtask

    task automatic test_length();
        do_clr();
        do_exe(1'b1, 1'b0, 32'h0000_0040, 12'd4);
        for (int i = 0; i < 3; i++) do_beat(16'h0040 + 16'(i), 1'b0);
        do_done();
        tick();
        n_checks++;
        if (err_type !== 4'b0010) begin
            n_fail++; $display("FAIL underrun got %b exp 0010", err_type);
        end
        do_clr();
        do_exe(1'b1, 1'b0, 32'h0000_0040, 12'd4);
        for (int i = 0; i < 5; i++) do_beat(16'h0040 + 16'(i), 1'b0);
        n_checks++;
        if (chk_busy !== 1'b1) begin
            n_fail++; $display("FAIL overrun_busy got %b exp 1", chk_busy);
        end
        do_done();
        tick();
        exp_stat = {1'b0, 1'b0, 1'b1, 4'b0001, 16'd0, 16'd1};
        n_checks++;
        if (stat !== exp_stat) begin
            n_fail++; $display("FAIL overrun_status got %h exp %h", stat, exp_stat);
        end
        // Last beat together with done counts toward the length
        do_clr();
        do_exe(1'b1, 1'b0, 32'h0000_0040, 12'd4);
        for (int i = 0; i < 3; i++) do_beat(16'h0040 + 16'(i), 1'b0);
        do_beat(16'h0043, 1'b1);
        tick();
        exp_stat = {1'b0, 1'b1, 1'b0, 4'h0, 16'd0, 16'd1};
        n_checks++;
        if (stat !== exp_stat) begin
            n_fail++; $display("FAIL beat_with_done got %h exp %h", stat, exp_stat);
        end
    endtask

    task automatic test_timeout();
        do_clr();
        do_exe(1'b1, 1'b0, 32'h0000_0000, 12'd4);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        n_checks++;
        if (chk_busy !== 1'b1) begin
            n_fail++; $display("FAIL timeout_early got busy=%b exp 1", chk_busy);
        end
        tick();
        exp_stat = {1'b0, 1'b0, 1'b1, 4'b1000, 16'd0, 16'd0};
        n_checks++;
        if (stat !== exp_stat) begin
            n_fail++; $display("FAIL timeout_status got %h exp %h", stat, exp_stat);
        end
    endtask

    task automatic test_protocol();
        do_clr();
        do_exe(1'b0, 1'b0, 32'h0000_0010, 12'd4);
        n_checks++;
        if ({chk_busy, err_type} !== 5'b0) begin
            n_fail++; $display("FAIL write_ignored got %b exp 00000", {chk_busy, err_type});
        end
        do_exe(1'b1, 1'b0, 32'h0000_0050, 12'd2);
        do_exe(1'b1, 1'b0, 32'h0000_0200, 12'd9);
        n_checks++;
        if ({chk_busy, err_type} !== 5'b1_0100) begin
            n_fail++; $display("FAIL exe_in_run got %b exp 10100", {chk_busy, err_type});
        end
        do_beat(16'h0050, 1'b0);
        do_beat(16'h0051, 1'b1);
        tick();
        exp_stat = {1'b0, 1'b0, 1'b1, 4'b0100, 16'd0, 16'd1};
        n_checks++;
        if (stat !== exp_stat) begin
            n_fail++; $display("FAIL exe_in_run_status got %h exp %h", stat, exp_stat);
        end
        do_clr();
        do_beat(16'h1234, 1'b0);
        tick();
        exp_stat = {1'b0, 1'b0, 1'b1, 4'b0100, 16'd0, 16'd0};
        n_checks++;
        if (stat !== exp_stat) begin
            n_fail++; $display("FAIL valid_in_idle got %h exp %h", stat, exp_stat);
        end
    endtask

    task automatic test_clear();
        // Build up errors, then clear
        do_exe(1'b1, 1'b0, 32'h0000_0300, 12'd2);
        do_beat(16'h0BAD, 1'b0);
        do_beat(16'h0301, 1'b1);
        tick();
        n_checks++;
        if (err_cnt !== 16'd1) begin
            n_fail++; $display("FAIL pre_clear_err got %h exp 1", err_cnt);
        end
        do_clr();
        exp_stat = '0;
        n_checks++;
        if ({stat, first_err_addr, first_err_data} !== {exp_stat, 48'd0}) begin
            n_fail++; $display("FAIL clear_all got %h exp %h", {stat, first_err_addr, first_err_data}, {exp_stat, 48'd0});
        end
        // Clear mid-burst: burst keeps being checked
        do_exe(1'b1, 1'b0, 32'h0000_0400, 12'd4);
        do_beat(16'h0400, 1'b0);
        do_clr();
        n_checks++;
        if (chk_busy !== 1'b1) begin
            n_fail++; $display("FAIL clear_keeps_run got %b exp 1", chk_busy);
        end
        for (int i = 1; i < 4; i++) do_beat(16'h0400 + 16'(i), 1'b0);
        do_done();
        tick();
        exp_stat = {1'b0, 1'b1, 1'b0, 4'h0, 16'd0, 16'd1};
        n_checks++;
        if (stat !== exp_stat) begin
            n_fail++; $display("FAIL clear_mid_burst got %h exp %h", stat, exp_stat);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_exe(1'b1, 1'b0, 32'h0000_0500, 12'd8);
        do_beat(16'h0500, 1'b0);
        do_beat(16'hFFFF, 1'b0);
        sys_rst = 1'b0;
        #2;
        n_checks++;
        if ({dbg_state, stat} !== 40'd0) begin
            n_fail++; $display("FAIL async_reset got %h exp 0", {dbg_state, stat});
        end
        tick();
        sys_rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({dbg_state, stat} !== 40'd0) begin
            n_fail++; $display("FAIL after_reset got %h exp 0", {dbg_state, stat});
        end
    endtask

    initial begin
        test_reset();
        test_clean_burst();
        test_data_error();
        test_wrap();
        test_length();
        test_timeout();
        test_protocol();
        test_clear();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
